cr_huf_comp_htb_long_rdr: RTL and testbench

CR_HUF_COMP_HTB_LONG_RDR -- requirements
Module: cr_huf_comp_htb_long_rdr

---
 rtl/cr_huf_comp_htb_long_rdr_if.sv | 32 +++
 rtl/cr_huf_comp_htb_long_rdr.sv | 283 ++++++++++++++++++++++++++++
 tb/tb_cr_huf_comp_htb_long_rdr.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cr_huf_comp_htb_long_rdr_if.sv
// Output stream of the long-table reader.
// The reader drives the data and valid signals. The consumer drives the
// ready signal.
//   out_vld    : beat available
//   out_rdy    : consumer accepts the beat
//   out_freq   : two sorted-frequency entries
//   out_val    : per-entry valid bits
//   out_seq_id : sequence ID of the table
//   out_last   : last beat of the table
//   out_err    : build error, only set on the last beat
interface cr_huf_comp_htb_long_rdr_if #(
  parameter int FREQ_WIDTH  = 20,
  parameter int SEQID_WIDTH = 8
);
  logic                     out_vld;
  logic                     out_rdy;
  logic [2*FREQ_WIDTH-1:0]  out_freq;
  logic [1:0]               out_val;
  logic [SEQID_WIDTH-1:0]   out_seq_id;
  logic                     out_last;
  logic                     out_err;

  modport master (
    output out_vld, out_freq, out_val, out_seq_id, out_last, out_err,
    input  out_rdy
  );

  modport slave (
    input  out_vld, out_freq, out_val, out_seq_id, out_last, out_err,
    output out_rdy
  );
endinterface

// File: rtl/cr_huf_comp_htb_long_rdr.sv
// Huffman long-table reader.
// When the tree builder reports a completed build, this block reads the
// sorted-frequency table. It reads two entries per access, at addresses
// 0..NUM_RD-1. It forwards each returned pair through a small output FIFO
// to a valid/ready consumer.
// A failed build or an empty build produces a single marker beat instead
// of reads. rd_done releases the builder once the consumer has taken
// every beat.
//
// Ports:
//   clk, rst_n                 : clock and asynchronous active-low reset
//   ht_hw_build_vld/_seq_id    : build-complete pulse and its sequence ID
//   ht_hw_build_error          : the build failed
//   ht_hw_zero_symbols         : the table is empty
//   hw_ht_not_ready            : the reader is busy with a table
//   hw_ht_sym_freq_rd/_rd_addr : read strobe and read address
//   hw_ht_sym_freq_seq_id      : sequence ID presented with each read
//   hw_ht_sym_freq_rd_done     : table consumed, one-cycle pulse
//   ht_hw_sym_sort_freq(_val)  : read data, RD_LATENCY cycles after the strobe
//   out_if                     : output stream (master side)
module cr_huf_comp_htb_long_rdr #(
  parameter int FREQ_WIDTH  = 20,
  parameter int SEQID_WIDTH = 8,
  parameter int NUM_RD      = 143,
  parameter int ADDR_WIDTH  = 8,
  parameter int RD_LATENCY  = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ht_hw_build_vld,
  input  logic [SEQID_WIDTH-1:0]   ht_hw_seq_id,
  input  logic                     ht_hw_build_error,
  input  logic                     ht_hw_zero_symbols,
  output logic                     hw_ht_not_ready,
  output logic                     hw_ht_sym_freq_rd,
  output logic [ADDR_WIDTH-1:0]    hw_ht_sym_freq_rd_addr,
  output logic [SEQID_WIDTH-1:0]   hw_ht_sym_freq_seq_id,
  output logic                     hw_ht_sym_freq_rd_done,
  input  logic [2*FREQ_WIDTH-1:0]  ht_hw_sym_sort_freq,
  input  logic [1:0]               ht_hw_sym_sort_freq_val,
  cr_huf_comp_htb_long_rdr_if.master out_if
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0]      DEPTH_C   = CNT_W'(FIFO_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_RD - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [SEQID_WIDTH-1:0]  seq_q;
  logic                    err_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic                    rd_q;
  logic [ADDR_WIDTH-1:0]   rd_addr_q;
  logic [SEQID_WIDTH-1:0]  rd_seq_q;
  logic                    done_q;
  logic                    not_ready_q;
  logic [CNT_W-1:0]        used_q, used_d;
  logic [RD_LATENCY-1:0]   inflight_q;
  logic [RD_LATENCY-1:0]   last_sr_q;

  logic [2*FREQ_WIDTH-1:0] f_freq_q [FIFO_DEPTH];
  logic [1:0]              f_val_q  [FIFO_DEPTH];
  logic [SEQID_WIDTH-1:0]  f_seq_q  [FIFO_DEPTH];
  logic                    f_last_q [FIFO_DEPTH];
  logic                    f_err_q  [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]        cnt_q, cnt_d;

  logic                    accept_s;
  logic                    issue_s;
  logic                    direct_s;
  logic                    push_s;
  logic                    pop_s;
  logic                    drain_empty_s;
  logic [2*FREQ_WIDTH-1:0] push_freq_s;
  logic [1:0]              push_val_s;
  logic [SEQID_WIDTH-1:0]  push_seq_s;
  logic                    push_last_s;
  logic                    push_err_s;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(FIFO_DEPTH - 1)) begin
      return PTR_W'(0);
    end else begin
      return p + PTR_W'(1);
    end
  endfunction

  assign pop_s = (cnt_q != CNT_W'(0)) && out_if.out_rdy;

  // used_q counts every FIFO slot that is reserved: reads in flight plus
  // beats that are buffered. So a count of one together with a pop means
  // the table is fully drained after this edge.
  assign drain_empty_s = (used_q == CNT_W'(0)) ||
                         ((used_q == CNT_W'(1)) && pop_s);

  // FSM next state, read issue and FIFO push selection
  always_comb begin
    state_d     = state_q;
    accept_s    = 1'b0;
    issue_s     = 1'b0;
    direct_s    = 1'b0;
    push_s      = inflight_q[RD_LATENCY-1];
    push_freq_s = ht_hw_sym_sort_freq;
    push_val_s  = ht_hw_sym_sort_freq_val;
    push_seq_s  = seq_q;
    push_last_s = last_sr_q[RD_LATENCY-1];
    push_err_s  = last_sr_q[RD_LATENCY-1] & err_q;
    case (state_q)
      ST_IDLE: begin
        if (ht_hw_build_vld) begin
          accept_s = 1'b1;
          if (!ht_hw_build_error && !ht_hw_zero_symbols) begin
            state_d = ST_READ;
          end else begin
            // Nothing to read: emit a single marker beat.
            direct_s    = 1'b1;
            push_s      = 1'b1;
            push_freq_s = {(2*FREQ_WIDTH){1'b0}};
            push_val_s  = 2'b00;
            push_seq_s  = ht_hw_seq_id;
            push_last_s = 1'b1;
            push_err_s  = ht_hw_build_error;
            state_d     = ST_DRAIN;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_READ: begin
        if (used_q < DEPTH_C) begin
          issue_s = 1'b1;
          if (addr_q == LAST_ADDR) begin
            state_d = ST_DRAIN;
          end else begin
            state_d = ST_READ;
          end
        end else begin
          state_d = ST_READ;
        end
      end
      ST_DRAIN: begin
        if (drain_empty_s) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Credit and occupancy arithmetic
  always_comb begin
    used_d = used_q;
    cnt_d  = cnt_q;
    case ({(issue_s | direct_s), pop_s})
      2'b10:   used_d = used_q + CNT_W'(1);
      2'b01:   used_d = used_q - CNT_W'(1);
      default: used_d = used_q;
    endcase
    case ({push_s, pop_s})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // FSM state and build context registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      seq_q       <= SEQID_WIDTH'(0);
      err_q       <= 1'b0;
      not_ready_q <= 1'b0;
      done_q      <= 1'b0;
      used_q      <= CNT_W'(0);
    end else begin
      state_q     <= state_d;
      not_ready_q <= (state_d != ST_IDLE);
      done_q      <= (state_d == ST_DONE);
      used_q      <= used_d;
      if (accept_s) begin
        seq_q <= ht_hw_seq_id;
        err_q <= ht_hw_build_error;
      end
    end
  end

  // Read address counter and registered read-port outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q    <= ADDR_WIDTH'(0);
      rd_q      <= 1'b0;
      rd_addr_q <= ADDR_WIDTH'(0);
      rd_seq_q  <= SEQID_WIDTH'(0);
    end else begin
      rd_q      <= issue_s;
      rd_addr_q <= issue_s ? addr_q : ADDR_WIDTH'(0);
      rd_seq_q  <= issue_s ? seq_q : SEQID_WIDTH'(0);
      if (accept_s) begin
        addr_q <= ADDR_WIDTH'(0);
      end else if (issue_s && (addr_q != LAST_ADDR)) begin
        addr_q <= addr_q + ADDR_WIDTH'(1);
      end
    end
  end

  // Shift registers that track each strobe until its data returns
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_q <= RD_LATENCY'(0);
      last_sr_q  <= RD_LATENCY'(0);
    end else begin
      for (int i = RD_LATENCY - 1; i > 0; i--) begin
        inflight_q[i] <= inflight_q[i-1];
        last_sr_q[i]  <= last_sr_q[i-1];
      end
      inflight_q[0] <= rd_q;
      last_sr_q[0]  <= rd_q && (rd_addr_q == LAST_ADDR);
    end
  end

  // Output FIFO storage and pointers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        f_freq_q[i] <= {(2*FREQ_WIDTH){1'b0}};
        f_val_q[i]  <= 2'b00;
        f_seq_q[i]  <= SEQID_WIDTH'(0);
        f_last_q[i] <= 1'b0;
        f_err_q[i]  <= 1'b0;
      end
      wr_ptr_q <= PTR_W'(0);
      rd_ptr_q <= PTR_W'(0);
      cnt_q    <= CNT_W'(0);
    end else begin
      if (push_s) begin
        f_freq_q[wr_ptr_q] <= push_freq_s;
        f_val_q[wr_ptr_q]  <= push_val_s;
        f_seq_q[wr_ptr_q]  <= push_seq_s;
        f_last_q[wr_ptr_q] <= push_last_s;
        f_err_q[wr_ptr_q]  <= push_err_s;
        wr_ptr_q           <= ptr_inc(wr_ptr_q);
      end
      if (pop_s) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      cnt_q <= cnt_d;
    end
  end

  assign hw_ht_not_ready        = not_ready_q;
  assign hw_ht_sym_freq_rd      = rd_q;
  assign hw_ht_sym_freq_rd_addr = rd_addr_q;
  assign hw_ht_sym_freq_seq_id  = rd_seq_q;
  assign hw_ht_sym_freq_rd_done = done_q;

  // The FIFO head is presented straight from storage. The entries are
  // cleared on reset, so every output is zero while the reader is in reset.
  assign out_if.out_vld    = (cnt_q != CNT_W'(0));
  assign out_if.out_freq   = f_freq_q[rd_ptr_q];
  assign out_if.out_val    = f_val_q[rd_ptr_q];
  assign out_if.out_seq_id = f_seq_q[rd_ptr_q];
  assign out_if.out_last   = f_last_q[rd_ptr_q];
  assign out_if.out_err    = f_err_q[rd_ptr_q];

endmodule

// File: tb/tb_cr_huf_comp_htb_long_rdr.sv
module tb_cr_huf_comp_htb_long_rdr;
  localparam int FW = 20;
  localparam int SW = 8;
  localparam int NR = 143;
  localparam int AW = 8;
  localparam int RL = 2;
  localparam int FD = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic build_vld = 1'b0;
  logic [SW-1:0] build_seq = '0;
  logic build_err = 1'b0;
  logic build_zero = 1'b0;
  logic not_ready, rd, rd_done;
  logic [AW-1:0] rd_addr;
  logic [SW-1:0] rd_seq;
  logic [2*FW-1:0] freq_in;
  logic [1:0] val_in;
  logic rdy = 1'b1;

  cr_huf_comp_htb_long_rdr_if #(.FREQ_WIDTH(FW), .SEQID_WIDTH(SW)) oif ();
  assign oif.out_rdy = rdy;

  cr_huf_comp_htb_long_rdr #(
    .FREQ_WIDTH(FW), .SEQID_WIDTH(SW), .NUM_RD(NR), .ADDR_WIDTH(AW),
    .RD_LATENCY(RL), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .ht_hw_build_vld(build_vld), .ht_hw_seq_id(build_seq),
    .ht_hw_build_error(build_err), .ht_hw_zero_symbols(build_zero),
    .hw_ht_not_ready(not_ready), .hw_ht_sym_freq_rd(rd),
    .hw_ht_sym_freq_rd_addr(rd_addr), .hw_ht_sym_freq_seq_id(rd_seq),
    .hw_ht_sym_freq_rd_done(rd_done),
    .ht_hw_sym_sort_freq(freq_in), .ht_hw_sym_sort_freq_val(val_in),
    .out_if(oif)
  );

  always #5 clk = ~clk;

  // ---------------- table memory model ----------------
  function automatic logic [2*FW-1:0] mem_freq(input logic [AW-1:0] a);
    logic [FW-1:0] hi, lo;
    hi = FW'(a) * FW'(3) + FW'(7);
    lo = ~FW'(a);
    return {hi, lo};
  endfunction

  function automatic logic [1:0] mem_val(input logic [AW-1:0] a);
    int v;
    v = int'(a) % 3;
    return 2'(v + 1);
  endfunction

  logic [RL-1:0] p_vld = '0;
  logic [AW-1:0] p_addr [RL] = '{default: '0};

  always @(posedge clk) begin
    for (int i = RL - 1; i > 0; i--) begin
      p_vld[i]  <= p_vld[i-1];
      p_addr[i] <= p_addr[i-1];
    end
    p_vld[0]  <= rd;
    p_addr[0] <= rd_addr;
  end

  // garbage outside the return slot exposes a wrong capture cycle
  assign freq_in = p_vld[RL-1] ? mem_freq(p_addr[RL-1]) : '1;
  assign val_in  = p_vld[RL-1] ? mem_val(p_addr[RL-1]) : 2'b11;

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [2*FW-1:0] freq;
    logic [1:0]      val;
    logic [SW-1:0]   seq;
    logic            last;
    logic            err;
  } beat_t;

  beat_t sb[$];

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  int reads_cnt = 0;
  int beats_cnt = 0;
  int done_cnt = 0;
  int last_pop_cyc = -10;
  int exp_addr = 0;
  logic [SW-1:0] cur_seq = '0;
  bit mon_en = 1'b0;
  bit rnd_mode = 1'b0;
  bit prev_hold = 1'b0;
  logic [63:0] prev_data = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // monitor: read port, output stream, done pulse
  always @(negedge clk) begin
    beat_t e;
    if (mon_en) begin
      if (rd) begin
        reads_cnt++;
        chk("rd_addr", 64'(rd_addr), 64'(exp_addr));
        chk("rd_seq", 64'(rd_seq), 64'(cur_seq));
        e.freq = mem_freq(rd_addr);
        e.val  = mem_val(rd_addr);
        e.seq  = cur_seq;
        e.last = (int'(rd_addr) == NR - 1);
        e.err  = 1'b0;
        sb.push_back(e);
        exp_addr++;
        chk("credit_bound", 64'(sb.size() <= FD), 64'd1);
      end else begin
        chk("rd_idle_zero", 64'({rd_seq, rd_addr}), 64'd0);
      end
      if (prev_hold) begin
        chk("hold_vld", 64'(oif.out_vld), 64'd1);
        chk("hold_data", {12'd0, oif.out_freq, oif.out_val, oif.out_seq_id,
                          oif.out_last, oif.out_err}, prev_data);
      end
      if (oif.out_vld && oif.out_rdy) begin
        if (sb.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_beat: got beat seq %0h expected none", oif.out_seq_id);
        end else begin
          e = sb.pop_front();
          chk("beat_freq", 64'(oif.out_freq), 64'(e.freq));
          chk("beat_val", 64'(oif.out_val), 64'(e.val));
          chk("beat_seq", 64'(oif.out_seq_id), 64'(e.seq));
          chk("beat_last", 64'(oif.out_last), 64'(e.last));
          chk("beat_err", 64'(oif.out_err), 64'(e.err));
        end
        beats_cnt++;
        if (oif.out_last) last_pop_cyc = cyc;
      end
      if (rd_done) begin
        done_cnt++;
        chk("done_timing", 64'(cyc), 64'(last_pop_cyc + 1));
      end
      prev_hold = oif.out_vld && !oif.out_rdy;
      prev_data = {12'd0, oif.out_freq, oif.out_val, oif.out_seq_id,
                   oif.out_last, oif.out_err};
    end else begin
      prev_hold = 1'b0;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_build(input logic [SW-1:0] s, input logic e, input logic z);
    beat_t b;
    @(posedge clk); #1;
    chk("ready_before_build", 64'(not_ready), 64'd0);
    build_vld = 1'b1; build_seq = s; build_err = e; build_zero = z;
    cur_seq = s;
    exp_addr = 0;
    if (e || z) begin
      b.freq = '0; b.val = 2'b00; b.seq = s; b.last = 1'b1; b.err = e;
      sb.push_back(b);
    end
    @(posedge clk); #1;
    build_vld = 1'b0; build_err = 1'b0; build_zero = 1'b0;
    chk("busy_after_build", 64'(not_ready), 64'd1);
  endtask

  task automatic wait_done(input int max_cyc);
    int d0;
    d0 = done_cnt;
    for (int i = 0; i < max_cyc; i++) begin
      @(posedge clk); #1;
      if (rnd_mode) rdy = 1'($urandom_range(0, 1));
      if (done_cnt != d0) break;
    end
    chk("done_seen", 64'(done_cnt - d0), 64'd1);
    rdy = 1'b1;
    rnd_mode = 1'b0;
  endtask

  typedef struct {
    logic [SW-1:0] seq;
    logic          err;
    logic          zero;
    bit            rnd;
    int            reads;
    int            beats;
  } vec_t;

  task automatic run_vec(input vec_t v);
    int d0;
    reads_cnt = 0; beats_cnt = 0;
    d0 = done_cnt;
    rdy = 1'b1;
    rnd_mode = v.rnd;
    do_build(v.seq, v.err, v.zero);
    wait_done(3000);
    repeat (3) @(posedge clk);
    #1;
    chk("vec_reads", 64'(reads_cnt), 64'(v.reads));
    chk("vec_beats", 64'(beats_cnt), 64'(v.beats));
    chk("vec_done_once", 64'(done_cnt - d0), 64'd1);
    chk("vec_sb_empty", 64'(sb.size()), 64'd0);
    chk("vec_idle_ready", 64'(not_ready), 64'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rdport"}, 64'({not_ready, rd, rd_addr, rd_seq, rd_done}), 64'd0);
    chk({tag, "_outctl"}, 64'({oif.out_vld, oif.out_val, oif.out_last, oif.out_err}), 64'd0);
    chk({tag, "_outdata"}, 64'({oif.out_freq, oif.out_seq_id}), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test expected completion");
    $fatal(1, "watchdog");
  end

  vec_t vecs[6];
  int d0;
  bit hit;

  initial begin
    vecs[0] = '{seq: 8'h5A, err: 1'b0, zero: 1'b0, rnd: 1'b0, reads: NR, beats: NR};
    vecs[1] = '{seq: 8'h33, err: 1'b1, zero: 1'b0, rnd: 1'b0, reads: 0,  beats: 1};
    vecs[2] = '{seq: 8'hC4, err: 1'b0, zero: 1'b1, rnd: 1'b0, reads: 0,  beats: 1};
    vecs[3] = '{seq: 8'h7E, err: 1'b1, zero: 1'b1, rnd: 1'b0, reads: 0,  beats: 1};
    vecs[4] = '{seq: 8'h11, err: 1'b0, zero: 1'b0, rnd: 1'b1, reads: NR, beats: NR};
    vecs[5] = '{seq: 8'hE7, err: 1'b0, zero: 1'b0, rnd: 1'b1, reads: NR, beats: NR};

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst_n = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);
    chk("no_rd_after_reset", 64'(rd), 64'd0);

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // back-pressure: consumer stalled, only FIFO_DEPTH reads go out
    reads_cnt = 0; beats_cnt = 0;
    rdy = 1'b0;
    do_build(8'h42, 1'b0, 1'b0);
    repeat (30) @(posedge clk);
    #1;
    chk("bp_reads", 64'(reads_cnt), 64'(FD));
    chk("bp_rd_low", 64'(rd), 64'd0);
    chk("bp_vld", 64'(oif.out_vld), 64'd1);
    chk("bp_pending", 64'(sb.size()), 64'(FD));
    rdy = 1'b1;
    wait_done(2000);
    chk("bp_total_reads", 64'(reads_cnt), 64'(NR));
    chk("bp_total_beats", 64'(beats_cnt), 64'(NR));

    // build pulse during READ must be ignored
    reads_cnt = 0; beats_cnt = 0;
    do_build(8'h21, 1'b0, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    chk("busy_in_read", 64'(not_ready), 64'd1);
    build_vld = 1'b1; build_seq = 8'h99; build_err = 1'b1; build_zero = 1'b1;
    @(posedge clk); #1;
    build_vld = 1'b0; build_err = 1'b0; build_zero = 1'b0;
    wait_done(2000);
    chk("ign_reads", 64'(reads_cnt), 64'(NR));
    chk("ign_beats", 64'(beats_cnt), 64'(NR));

    // reset in the middle of a table
    do_build(8'h70, 1'b0, 1'b0);
    hit = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(posedge clk); #1;
      if (exp_addr > 70) begin
        hit = 1'b1;
        break;
      end
    end
    chk("reached_addr70", 64'(hit), 64'd1);
    mon_en = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_all_zero("midreset");
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("inreset");
    rst_n = 1'b1;
    sb.delete();
    exp_addr = 0;
    last_pop_cyc = -10;
    d0 = done_cnt;
    mon_en = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("no_done_after_abandon", 64'(done_cnt - d0), 64'd0);
    chk("no_beats_after_abandon", 64'(oif.out_vld), 64'd0);
    run_vec('{seq: 8'h3C, err: 1'b0, zero: 1'b0, rnd: 1'b0, reads: NR, beats: NR});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
